// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting block: FSM encoding, field
// select codes, default field limits and the wrap-around step helper.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  localparam int DEF_MAX_SEC  = 59;
  localparam int DEF_MAX_HOUR = 23;

  // Opposing up/down requests cancel so the field is left untouched.
  function automatic int wrap_step(int val, int max, logic up, logic down);
    if (up && !down) return (val >= max) ? 0 : val + 1;
    if (down && !up) return (val == 0) ? max : val - 1;
    return val;
  endfunction

endpackage

// File: rtl/clock_time_setter_rise_detect.sv
// One-cycle rising-edge detector for a synchronous, debounced level input.
module rise_detect (
  input  logic clk,
  input  logic rst_a_n,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) prev <= 1'b0;
    else          prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/clock_time_setter.sv
// Button-driven HH:MM:SS setter: shadows the live time on entry, lets the user
// step and adjust hour/min/sec, then strobes load with the new values on exit.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int SEC_W     = 6,
  parameter int HOUR_W    = 5,
  parameter int MAX_SEC   = DEF_MAX_SEC,
  parameter int MAX_HOUR  = DEF_MAX_HOUR,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_a_n,
  input  logic              set_mode,
  input  logic              btn_next,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [SEC_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] cur_hour,
  output logic [SEC_W-1:0]  set_sec,
  output logic [SEC_W-1:0]  set_min,
  output logic [HOUR_W-1:0] set_hour,
  output logic              load,
  output logic              setting,
  output logic [1:0]        field_sel,
  output logic              blink,
  output logic [2:0]        fsm_state
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t             state;
  logic               mode_rise, next_rise, up_rise, down_rise;
  logic               in_set;
  logic [BLINK_W-1:0] blink_cnt;

  rise_detect u_mode (.clk(clk), .rst_a_n(rst_a_n), .in(set_mode), .rise(mode_rise));
  rise_detect u_next (.clk(clk), .rst_a_n(rst_a_n), .in(btn_next), .rise(next_rise));
  rise_detect u_up   (.clk(clk), .rst_a_n(rst_a_n), .in(btn_up),   .rise(up_rise));
  rise_detect u_down (.clk(clk), .rst_a_n(rst_a_n), .in(btn_down), .rise(down_rise));

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state     <= ST_IDLE;
      set_sec   <= '0;
      set_min   <= '0;
      set_hour  <= '0;
      load      <= 1'b0;
      setting   <= 1'b0;
      field_sel <= FIELD_NONE;
    end else begin
      load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mode_rise) begin
            set_sec   <= cur_sec;
            set_min   <= cur_min;
            set_hour  <= cur_hour;
            state     <= ST_SET_HOUR;
            setting   <= 1'b1;
            field_sel <= FIELD_HOUR;
          end
        end
        ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
          // Leaving set mode takes priority over any button edge this cycle.
          if (!set_mode) begin
            state     <= ST_COMMIT;
            load      <= 1'b1;
            setting   <= 1'b0;
            field_sel <= FIELD_NONE;
          end else begin
            case (state)
              ST_SET_HOUR: set_hour <= HOUR_W'(wrap_step(int'(set_hour), MAX_HOUR, up_rise, down_rise));
              ST_SET_MIN:  set_min  <= SEC_W'(wrap_step(int'(set_min), MAX_SEC, up_rise, down_rise));
              default:     set_sec  <= SEC_W'(wrap_step(int'(set_sec), MAX_SEC, up_rise, down_rise));
            endcase
            if (next_rise) begin
              case (state)
                ST_SET_HOUR: begin state <= ST_SET_MIN;  field_sel <= FIELD_MIN;  end
                ST_SET_MIN:  begin state <= ST_SET_SEC;  field_sel <= FIELD_SEC;  end
                default:     begin state <= ST_SET_HOUR; field_sel <= FIELD_HOUR; end
              endcase
            end
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign in_set = set_mode &&
                  (state == ST_SET_HOUR || state == ST_SET_MIN || state == ST_SET_SEC);

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!in_set) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: reset, table-driven set sequence, hand-written
// corner cases and a randomized run checked against a field-array model.
module tb_clock_time_setter;
  import clock_pkg::*;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_a_n = 1'b0;
  logic       set_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] cur_sec = '0, cur_min = '0;
  logic [4:0] cur_hour = '0;
  logic [5:0] set_sec, set_min;
  logic [4:0] set_hour;
  logic       load, setting, blink;
  logic [1:0] field_sel;
  logic [2:0] fsm_state;

  clock_time_setter #(.BLINK_DIV(BD)) dut (
    .clk(clk), .rst_a_n(rst_a_n), .set_mode(set_mode), .btn_next(btn_next),
    .btn_up(btn_up), .btn_down(btn_down), .cur_sec(cur_sec), .cur_min(cur_min),
    .cur_hour(cur_hour), .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
    .load(load), .setting(setting), .field_sel(field_sel), .blink(blink),
    .fsm_state(fsm_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // reference model: mode 0 idle, 1..3 = setting field (hour,min,sec), 4 commit
  int   m_st;
  int   m_f[3];
  int   m_max[3] = '{23, 59, 59};
  int   m_bn;
  logic p_mode, p_next, p_up, p_down;

  function automatic void model_reset();
    m_st = 0; m_f[0] = 0; m_f[1] = 0; m_f[2] = 0; m_bn = 0;
    p_mode = 1'b0; p_next = 1'b0; p_up = 1'b0; p_down = 1'b0;
  endfunction

  function automatic void model_step();
    logic r_mode, r_next, r_up, r_down;
    int   i;
    r_mode = set_mode & ~p_mode;
    r_next = btn_next & ~p_next;
    r_up   = btn_up & ~p_up;
    r_down = btn_down & ~p_down;
    if (m_st == 0) begin
      if (r_mode) begin
        m_f[0] = int'(cur_hour); m_f[1] = int'(cur_min); m_f[2] = int'(cur_sec);
        m_st = 1; m_bn = 0;
      end
    end else if (m_st <= 3) begin
      if (!set_mode) m_st = 4;
      else begin
        i = m_st - 1;
        if (r_up && !r_down)      m_f[i] = (m_f[i] + 1) % (m_max[i] + 1);
        else if (r_down && !r_up) m_f[i] = (m_f[i] + m_max[i]) % (m_max[i] + 1);
        if (r_next) m_st = (m_st % 3) + 1;
        m_bn++;
      end
    end else m_st = 0;
    p_mode = set_mode; p_next = btn_next; p_up = btn_up; p_down = btn_down;
  endfunction

  function automatic logic [2:0] exp_state(int s);
    case (s)
      1:       return ST_SET_HOUR;
      2:       return ST_SET_MIN;
      3:       return ST_SET_SEC;
      4:       return ST_COMMIT;
      default: return ST_IDLE;
    endcase
  endfunction

  // scoreboard
  task automatic check(string name, int got, int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_model(string name);
    logic [24:0] g, e;
    logic        in_set;
    in_set = (m_st >= 1 && m_st <= 3);
    g = {load, setting, field_sel, blink, set_hour, set_min, set_sec, fsm_state};
    e = {m_st == 4, in_set, in_set ? 2'(m_st) : 2'b00,
         in_set ? ((m_bn / BD) % 2 == 1) : 1'b0,
         5'(m_f[0]), 6'(m_f[1]), 6'(m_f[2]), exp_state(m_st)};
    compared++;
    if (g !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, g, e, $time);
    end
  endtask

  // driver tasks
  task automatic drive(logic mode, logic nxt, logic up, logic dn);
    set_mode = mode; btn_next = nxt; btn_up = up; btn_down = dn;
  endtask

  task automatic set_cur(int h, int m, int s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  task automatic tick(string name);
    model_step();
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  task automatic async_reset();
    drive(0, 0, 0, 0);
    rst_a_n = 1'b0;
    model_reset();
    #2;
    check_model("async_reset");
    check("rst_load", int'(load), 0);
    check("rst_state", int'(fsm_state), int'(ST_IDLE));
    #2;
    rst_a_n = 1'b1;
  endtask

  typedef struct {
    logic mode, nxt, up, dn;
    int   sel, h, m, s;
    logic ld, st;
  } vec_t;

  vec_t vecs[19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset_state");
    check("reset_outputs", int'({load, setting, field_sel, blink, set_hour, set_min, set_sec}), 0);
    #4;
    rst_a_n = 1'b1;

    // reset in the middle of SET_MIN discards shadows and yields no load
    set_cur(10, 30, 20);
    drive(1, 0, 0, 0); tick("a_enter");
    check("a_enter_sel", int'(field_sel), 1);
    drive(1, 1, 0, 0); tick("a_next");
    drive(1, 0, 0, 0); tick("a_rel");
    check("a_min_sel", int'(field_sel), 2);
    check("a_min_val", int'(set_min), 30);
    async_reset();
    check("a_min_cleared", int'(set_min), 0);
    for (int i = 0; i < 5; i++) begin
      tick("a_after");
      check("a_no_load", int'(load), 0);
    end

    // hour, minute and second wrap-around
    set_cur(23, 59, 0);
    drive(1, 0, 0, 0); tick("b_enter");
    check("b_cap_hour", int'(set_hour), 23);
    drive(1, 0, 1, 0); tick("b_up");
    check("b_hour_wrap_up", int'(set_hour), 0);
    drive(1, 0, 0, 0); tick("b_rel");
    drive(1, 0, 0, 1); tick("b_down");
    check("b_hour_wrap_down", int'(set_hour), 23);
    drive(1, 0, 0, 0); tick("b_rel");
    drive(1, 1, 0, 0); tick("b_next1");
    check("b_sel_min", int'(field_sel), 2);
    drive(1, 0, 1, 0); tick("b_min_up");
    check("b_min_wrap", int'(set_min), 0);
    drive(1, 1, 0, 0); tick("b_next2");
    check("b_sel_sec", int'(field_sel), 3);
    drive(1, 0, 0, 1); tick("b_sec_down");
    check("b_sec_wrap", int'(set_sec), 59);
    drive(1, 1, 0, 0); tick("b_next3");
    check("b_sel_hour", int'(field_sel), 1);
    drive(0, 0, 0, 0); tick("b_exit");
    check("b_load", int'(load), 1);
    check("b_load_val", int'({set_hour, set_min, set_sec}), int'({5'd23, 6'd0, 6'd59}));
    tick("b_idle");
    check("b_load_once", int'(load), 0);

    // next+up together adjusts the old field; mode fall beats a button edge
    set_cur(5, 0, 0);
    drive(1, 0, 0, 0); tick("c_enter");
    drive(1, 1, 1, 0); tick("c_next_up");
    check("c_hour", int'(set_hour), 6);
    check("c_sel", int'(field_sel), 2);
    drive(1, 0, 0, 0); tick("c_rel");
    drive(0, 0, 1, 0); tick("c_exit_up");
    check("c_commit", int'(fsm_state), int'(ST_COMMIT));
    check("c_min_kept", int'(set_min), 0);
    check("c_commit_load", int'(load), 1);
    drive(0, 0, 0, 0); tick("c_idle");
    check("c_idle_state", int'(fsm_state), int'(ST_IDLE));

    // held button steps once; blink toggles every BD cycles while setting
    set_cur(7, 8, 9);
    drive(1, 0, 0, 0); tick("d_enter");
    drive(1, 0, 1, 0);
    for (int k = 1; k <= 1000; k++) begin
      tick("d_hold");
      check("d_blink", int'(blink), (k / BD) % 2);
    end
    check("d_hour_once", int'(set_hour), 8);
    drive(0, 0, 0, 0); tick("d_exit");
    tick("d_idle");
    check("d_blink_idle", int'(blink), 0);
    check("d_setting_idle", int'(setting), 0);

    // table-driven set sequence from 12:34:56
    vecs[0]  = '{1, 0, 0, 0, 1, 12, 34, 56, 0, 1};
    vecs[1]  = '{1, 0, 1, 0, 1, 13, 34, 56, 0, 1};
    vecs[2]  = '{1, 0, 0, 0, 1, 13, 34, 56, 0, 1};
    vecs[3]  = '{1, 0, 0, 1, 1, 12, 34, 56, 0, 1};
    vecs[4]  = '{1, 0, 0, 0, 1, 12, 34, 56, 0, 1};
    vecs[5]  = '{1, 0, 1, 1, 1, 12, 34, 56, 0, 1};
    vecs[6]  = '{1, 0, 0, 0, 1, 12, 34, 56, 0, 1};
    vecs[7]  = '{1, 1, 0, 0, 2, 12, 34, 56, 0, 1};
    vecs[8]  = '{1, 0, 0, 0, 2, 12, 34, 56, 0, 1};
    vecs[9]  = '{1, 0, 1, 0, 2, 12, 35, 56, 0, 1};
    vecs[10] = '{1, 0, 0, 0, 2, 12, 35, 56, 0, 1};
    vecs[11] = '{1, 1, 0, 0, 3, 12, 35, 56, 0, 1};
    vecs[12] = '{1, 0, 0, 0, 3, 12, 35, 56, 0, 1};
    vecs[13] = '{1, 0, 0, 1, 3, 12, 35, 55, 0, 1};
    vecs[14] = '{1, 0, 0, 0, 3, 12, 35, 55, 0, 1};
    vecs[15] = '{1, 1, 0, 0, 1, 12, 35, 55, 0, 1};
    vecs[16] = '{1, 0, 0, 0, 1, 12, 35, 55, 0, 1};
    vecs[17] = '{0, 0, 0, 0, 0, 12, 35, 55, 1, 0};
    vecs[18] = '{0, 0, 0, 0, 0, 12, 35, 55, 0, 0};
    set_cur(12, 34, 56);
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].mode, vecs[i].nxt, vecs[i].up, vecs[i].dn);
      tick("tbl_model");
      check($sformatf("tbl%0d_out", i),
            int'({field_sel, set_hour, set_min, set_sec, load, setting}),
            int'({2'(vecs[i].sel), 5'(vecs[i].h), 6'(vecs[i].m), 6'(vecs[i].s),
                  vecs[i].ld, vecs[i].st}));
    end

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) async_reset();
      if ($urandom_range(39) == 0) set_mode = ~set_mode;
      btn_next = ($urandom_range(5) == 0);
      btn_up   = ($urandom_range(2) == 0);
      btn_down = ($urandom_range(2) == 0);
      set_cur($urandom_range(23), $urandom_range(59), $urandom_range(59));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
